// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings, PC sequencer states and
// instruction size.
package cpu_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_ABS = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, and push+pop together replaces the top in place.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW:0]      count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop) begin
      mem[ptr] <= din;
    end else if (push) begin
      // ptr wraps naturally, so a full stack overwrites its oldest slot
      mem[ptr + PW'(1)] <= din;
      ptr               <= ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter unit: four-source next-PC select, stall, halt/resume and
// misaligned-target trap. Define PC_RAS_EN to add the return-address stack.
module pc_seq_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [PC_WIDTH-1:0]  TRAP_VEC  = PC_WIDTH'(32'h0000_0100),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                stall,
  input  logic                halt,
  input  logic                resume,
  input  logic [1:0]          PCSrc,
  input  logic [PC_WIDTH-1:0] branch_off,
  input  logic [PC_WIDTH-1:0] AluOutput,
  input  logic                call,
  output logic [PC_WIDTH-1:0] curPC,
  output logic [PC_WIDTH-1:0] nextPC,
  output logic [PC_WIDTH-1:0] epc,
  output logic                trap,
  output logic                halted
);

  pc_state_e           state, state_nxt;
  pc_src_e             src;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] ret_pc;
  logic                ret_empty;
  logic                misaligned;
  logic                trap_req;
  logic                accept;

  assign src    = pc_src_e'(PCSrc);
  assign seq_pc = curPC + PC_WIDTH'(INSN_BYTES);

`ifdef PC_RAS_EN
  logic ras_full;

  pc_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (accept && call),
    .pop   (accept && (src == PC_RET)),
    .din   (seq_pc),
    .top   (ret_pc),
    .empty (ret_empty),
    .full  (ras_full)
  );

  logic unused_ras_full;
  assign unused_ras_full = ras_full;
`else
  // Without a stack, a return is simply an absolute jump to AluOutput.
  assign ret_pc    = AluOutput;
  assign ret_empty = 1'b0;

  logic        unused_call;
  logic [31:0] unused_ras_depth;
  assign unused_call      = call;
  assign unused_ras_depth = 32'(RAS_DEPTH);
`endif

  always_comb begin
    nextPC = seq_pc;
    unique case (src)
      PC_SEQ: nextPC = seq_pc;
      PC_BR:  nextPC = curPC + branch_off;
      PC_ABS: nextPC = AluOutput;
      PC_RET: nextPC = ret_pc;
    endcase
  end

  assign misaligned = (src != PC_SEQ) && (nextPC[1:0] != 2'b00);
  assign trap_req   = (state == RUN) && (misaligned || (src == PC_RET && ret_empty));
  assign accept     = (state == RUN) && !trap_req && !halt && !stall;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (!trap_req && halt) state_nxt = HALT;
      HALT: if (resume)            state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      curPC <= RESET_PC;
      epc   <= '0;
      trap  <= 1'b0;
    end else begin
      trap <= trap_req;
      if (trap_req) begin
        curPC <= TRAP_VEC;
        epc   <= curPC;
      end else if (accept) begin
        curPC <= nextPC;
      end
    end
  end

  assign halted = (state == HALT);

endmodule
